// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace multiplier.
package wallace_pkg;

    localparam int MAX_STAGES = 6;
    localparam int MAX_WIDTH  = 64;

    // Rows left after applying a number of 3:2 layers; leftover rows pass through.
    function automatic int csa_rows_after(int n_rows, int layers);
        int r;
        r = n_rows;
        for (int i = 0; i < layers; i++) begin
            if (r > 2) r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    // Number of 3:2 layers needed to bring n_rows operands down to two vectors.
    function automatic int csa_layer_count(int n_rows);
        int r;
        int c;
        r = n_rows;
        c = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            c++;
        end
        return c;
    endfunction

    // Pipeline registers placed after layer boundary pos (0 = raw partial products).
    // The remaining register always sits after the final adder.
    function automatic int regs_at_layer(int layers, int stages, int pos);
        int n;
        n = 0;
        for (int k = 1; k < stages; k++) begin
            if ((k * layers) / stages == pos) n++;
        end
        return n;
    endfunction

    // Baugh-Wooley correction: 2^width + 2^(2*width-1), modulo 2^(2*width).
    function automatic logic [2*MAX_WIDTH-1:0] bw_correction(int width);
        logic [2*MAX_WIDTH-1:0] c;
        c = '0;
        c[width] = 1'b1;
        c[2*width-1] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_row.sv
// Row of full adders: three vectors in, sum and left-shifted carry vectors out.
module csa_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    // Carry weight is one bit higher; the MSB carry falls off (result is modulo 2^WIDTH).
    assign carry = maj << 1;

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined signed/unsigned multiplier: Baugh-Wooley partial products, 3:2 CSA
// tree with registers spread over the layers, Kogge-Stone final adder, registered out.
// The whole pipe shares one advance enable, so backpressure freezes every stage.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int PW      = 2 * WIDTH;
    localparam int N0      = WIDTH + 1;          // partial products plus correction row
    localparam int LAYERS  = csa_layer_count(N0);
    localparam int FLAT    = N0 * PW;
    localparam int KS_LVLS = $clog2(PW);

    localparam logic [2*MAX_WIDTH-1:0] BW_FULL = bw_correction(WIDTH);
    localparam logic [PW-1:0]          BW_CORR = BW_FULL[PW-1:0];

    logic adv;
    logic [FLAT-1:0] pp_flat;
    logic [FLAT-1:0] pre_rows  [0:LAYERS];
    logic [FLAT-1:0] post_rows [0:LAYERS];
    logic            pre_valid [0:LAYERS];
    logic            post_valid[0:LAYERS];

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    // Partial products; in signed mode the terms pairing exactly one sign bit are inverted.
    always_comb begin
        pp_flat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_flat[i*PW + i + j] = (a[j] & b[i])
                                      ^ (is_signed & ((i == WIDTH-1) ^ (j == WIDTH-1)));
            end
        end
        pp_flat[WIDTH*PW +: PW] = is_signed ? BW_CORR : '0;
    end

    assign pre_rows[0]  = pp_flat;
    assign pre_valid[0] = in_valid & in_ready;

    // Register boundaries: zero or more pipeline registers after each layer.
    for (genvar p = 0; p <= LAYERS; p++) begin : g_pos
        localparam int NR   = csa_rows_after(N0, p);
        localparam int NREG = regs_at_layer(LAYERS, STAGES, p);

        if (NREG == 0) begin : g_wire
            assign post_rows[p][NR*PW-1:0] = pre_rows[p][NR*PW-1:0];
            assign post_valid[p]           = pre_valid[p];
        end else begin : g_regs
            logic [NR*PW-1:0] q [0:NREG-1];
            logic [NREG-1:0]  qv;

            // Stage valid bits: cleared by reset, shifted when the pipe advances.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qv <= '0;
                end else if (adv) begin
                    qv[0] <= pre_valid[p];
                    for (int r = 1; r < NREG; r++) qv[r] <= qv[r-1];
                end
            end

            // Stage data: unreset, loaded only when a real transaction moves in.
            always_ff @(posedge clk) begin
                if (adv) begin
                    if (pre_valid[p]) q[0] <= pre_rows[p][NR*PW-1:0];
                    for (int r = 1; r < NREG; r++) begin
                        if (qv[r-1]) q[r] <= q[r-1];
                    end
                end
            end

            assign post_rows[p][NR*PW-1:0] = q[NREG-1];
            assign post_valid[p]           = qv[NREG-1];
        end

        if (NR < N0) begin : g_pad
            assign post_rows[p][FLAT-1:NR*PW] = '0;
        end
    end

    // CSA layers: each group of three rows becomes sum+carry; leftovers pass through.
    for (genvar l = 1; l <= LAYERS; l++) begin : g_layer
        localparam int NI = csa_rows_after(N0, l-1);
        localparam int G  = NI / 3;
        localparam int NO = csa_rows_after(N0, l);

        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_row #(.WIDTH(PW)) u_csa (
                .x     (post_rows[l-1][(3*g)*PW   +: PW]),
                .y     (post_rows[l-1][(3*g+1)*PW +: PW]),
                .z     (post_rows[l-1][(3*g+2)*PW +: PW]),
                .sum   (pre_rows[l][(2*g)*PW   +: PW]),
                .carry (pre_rows[l][(2*g+1)*PW +: PW])
            );
        end

        for (genvar k = 0; k < NI - 3*G; k++) begin : g_pass
            assign pre_rows[l][(2*G+k)*PW +: PW] = post_rows[l-1][(3*G+k)*PW +: PW];
        end

        if (NO < N0) begin : g_zero
            assign pre_rows[l][FLAT-1:NO*PW] = '0;
        end

        assign pre_valid[l] = post_valid[l-1];
    end

    // Kogge-Stone prefix adder over the final two vectors.
    logic [PW-1:0] fin_x;
    logic [PW-1:0] fin_y;
    logic [PW-1:0] fin_sum;
    logic [PW-1:0] gk [0:KS_LVLS];
    logic [PW-1:0] pk [0:KS_LVLS];

    assign fin_x = post_rows[LAYERS][0  +: PW];
    assign fin_y = post_rows[LAYERS][PW +: PW];
    assign gk[0] = fin_x & fin_y;
    assign pk[0] = fin_x ^ fin_y;

    for (genvar lv = 0; lv < KS_LVLS; lv++) begin : g_ks
        localparam int D = 1 << lv;
        assign gk[lv+1] = gk[lv] | (pk[lv] & (gk[lv] << D));
        assign pk[lv+1] = pk[lv] & (pk[lv] << D);
    end

    assign fin_sum = pk[0] ^ (gk[KS_LVLS] << 1);

    // Output register: out cleared by reset, updated only by valid transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (adv) begin
            out_valid <= post_valid[LAYERS];
            if (post_valid[LAYERS]) out <= fin_sum;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: directed cases at 32/3, random regressions at 8/1 and 16/4.
module tb_wallace_mult_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        m_in_valid, m_in_ready, m_is_signed, m_out_valid, m_out_ready;
    logic [31:0] m_a, m_b;
    logic [63:0] m_out;

    logic        n8_in_valid, n8_in_ready, n8_is_signed, n8_out_valid, n8_out_ready;
    logic [7:0]  n8_a, n8_b;
    logic [15:0] n8_out;

    logic        n16_in_valid, n16_in_ready, n16_is_signed, n16_out_valid, n16_out_ready;
    logic [15:0] n16_a, n16_b;
    logic [31:0] n16_out;

    wallace_mult_pipe #(.WIDTH(32), .STAGES(3)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .is_signed(m_is_signed), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .out(m_out)
    );

    wallace_mult_pipe #(.WIDTH(8), .STAGES(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(n8_in_valid), .in_ready(n8_in_ready),
        .a(n8_a), .b(n8_b), .is_signed(n8_is_signed), .out_valid(n8_out_valid),
        .out_ready(n8_out_ready), .out(n8_out)
    );

    wallace_mult_pipe #(.WIDTH(16), .STAGES(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(n16_in_valid), .in_ready(n16_in_ready),
        .a(n16_a), .b(n16_b), .is_signed(n16_is_signed), .out_valid(n16_out_valid),
        .out_ready(n16_out_ready), .out(n16_out)
    );

    // Reference product: interpret operands as w-bit integers, multiply, keep 2w bits.
    function automatic logic [127:0] ref_mult(logic [63:0] a, logic [63:0] b, logic s, int w);
        logic signed [127:0] xa, xb, p;
        logic [127:0] mask;
        xa = {64'b0, a};
        xb = {64'b0, b};
        if (s && a[w-1]) xa = xa - (128'sd1 <<< w);
        if (s && b[w-1]) xb = xb - (128'sd1 <<< w);
        p = xa * xb;
        mask = (128'd1 << (2*w)) - 128'd1;
        return p & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid); end
        total++; if (m_out !== 64'd0) begin bad++; $display("FAIL reset_out: got %h want 0", m_out); end
        total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready); end
        total++; if (n8_out_valid !== 1'b0 || n16_out_valid !== 1'b0) begin bad++; $display("FAIL reset_small_valid: got %b%b want 00", n8_out_valid, n16_out_valid); end
        rst_n = 1'b1;
        tick();
        total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", m_in_ready); end
    endtask

    task automatic test_unsigned();
        int lat;
        m_out_ready = 1'b1;
        m_a = 32'hFFFF_FFFF; m_b = 32'hFFFF_FFFF; m_is_signed = 1'b0; m_in_valid = 1'b1;
        #1;
        total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL uns_in_ready: got %b want 1", m_in_ready); end
        tick();
        m_in_valid = 1'b0; m_a = 32'h1234_5678; m_b = 32'h9ABC_DEF0;
        lat = 1;
        while (m_out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (lat != 3) begin bad++; $display("FAIL uns_latency: got %0d want 3", lat); end
        total++; if (m_out !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL uns_max: got %h want fffffffe00000001", m_out); end
        tick();
        total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL uns_single: got out_valid %b want 0", m_out_valid); end
    endtask

    task automatic test_signed();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [63:0] te [3];
        int lat;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; te[0] = 64'h0000_0000_0000_0001;
        ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000; te[1] = 64'h4000_0000_0000_0000;
        ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0001; te[2] = 64'hFFFF_FFFF_8000_0000;
        m_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_a = ta[i]; m_b = tb[i]; m_is_signed = 1'b1; m_in_valid = 1'b1;
            tick();
            m_in_valid = 1'b0; m_is_signed = 1'b0;
            lat = 1;
            while (m_out_valid !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            total++;
            if (lat != 3 || m_out !== te[i]) begin
                bad++;
                $display("FAIL signed_%0d: got %h after %0d cycles want %h after 3", i, m_out, lat, te[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q[$];
        logic [127:0] r;
        int sent = 0, got = 0, first = -1, cyc = 0;
        m_out_ready = 1'b1;
        while ((sent < 10 || got < 10) && cyc < 60) begin
            if (sent < 10) begin
                m_in_valid = 1'b1; m_a = $urandom; m_b = $urandom; m_is_signed = sent[0];
            end else begin
                m_in_valid = 1'b0;
            end
            #1;
            if (m_out_valid === 1'b1) begin
                total++;
                if (q.size() == 0 || m_out !== q[0]) begin
                    bad++;
                    $display("FAIL b2b_data_%0d: got %h want %h", got, m_out, (q.size() > 0) ? q[0] : 64'hx);
                end
                if (q.size() > 0) void'(q.pop_front());
                if (first < 0) begin
                    first = cyc;
                    total++; if (first != 3) begin bad++; $display("FAIL b2b_first: got cycle %0d want 3", first); end
                end else begin
                    total++; if (cyc != first + got) begin bad++; $display("FAIL b2b_gap: got cycle %0d want %0d", cyc, first + got); end
                end
                got++;
            end
            if (m_in_valid && m_in_ready === 1'b1) begin
                r = ref_mult({32'b0, m_a}, {32'b0, m_b}, m_is_signed, 32);
                q.push_back(r[63:0]);
                sent++;
            end
            tick();
            cyc++;
        end
        m_in_valid = 1'b0;
        total++; if (got != 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", got); end
    endtask

    task automatic test_backpressure();
        logic [63:0] q[$];
        logic [127:0] r;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            m_out_ready = (cyc >= 8);
            m_in_valid  = (cyc < 10);
            m_a = $urandom; m_b = $urandom; m_is_signed = 1'($urandom_range(0, 1));
            #1;
            if (cyc >= 3 && cyc < 8) begin
                total++; if (m_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d: got %b want 0", cyc, m_in_ready); end
                total++;
                if (m_out_valid !== 1'b1 || q.size() == 0 || m_out !== q[0]) begin
                    bad++;
                    $display("FAIL bp_hold_%0d: got valid %b out %h want valid 1 out %h", cyc, m_out_valid, m_out, (q.size() > 0) ? q[0] : 64'hx);
                end
            end
            if (cyc == 8) begin
                total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", m_in_ready); end
            end
            if (m_out_valid === 1'b1 && m_out_ready) begin
                total++;
                if (q.size() == 0 || m_out !== q[0]) begin
                    bad++;
                    $display("FAIL bp_data_%0d: got %h want %h", got, m_out, (q.size() > 0) ? q[0] : 64'hx);
                end
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end
            if (m_in_valid && m_in_ready === 1'b1) begin
                r = ref_mult({32'b0, m_a}, {32'b0, m_b}, m_is_signed, 32);
                q.push_back(r[63:0]);
                sent++;
            end
            tick();
        end
        m_in_valid = 1'b0;
        m_out_ready = 1'b1;
        total++; if (sent != 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", sent); end
        total++; if (got != 5) begin bad++; $display("FAIL bp_delivered: got %0d want 5", got); end
    endtask

    task automatic test_reset_midflight();
        m_out_ready = 1'b1;
        m_in_valid = 1'b1; m_a = 32'd7; m_b = 32'd9; m_is_signed = 1'b0;
        tick();
        m_a = 32'd11; m_b = 32'd13;
        tick();
        m_in_valid = 1'b0;
        tick();
        total++; if (m_out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", m_out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b want 0", m_out_valid); end
        total++; if (m_out !== 64'd0) begin bad++; $display("FAIL rst_async_out: got %h want 0", m_out); end
        total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", m_in_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_%0d: got out_valid %b want 0", i, m_out_valid); end
        end
    endtask

    task automatic test_random(input int which, input int n);
        logic [63:0] q[$];
        logic [127:0] r;
        logic [63:0] av, bv, o, prev_out, wmask;
        logic iv, orr, sv, ov, ir, prev_stall;
        int sent = 0, got = 0, cyc = 0, w;
        w = (which == 0) ? 8 : 16;
        wmask = (64'd1 << w) - 64'd1;
        prev_stall = 1'b0;
        prev_out = '0;
        while ((sent < n || q.size() > 0) && cyc < 4000) begin
            iv  = (sent < n) && ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 9) < 7);
            av  = {$urandom, $urandom} & wmask;
            bv  = {$urandom, $urandom} & wmask;
            sv  = 1'($urandom_range(0, 1));
            if (which == 0) begin
                n8_in_valid = iv; n8_out_ready = orr; n8_a = av[7:0]; n8_b = bv[7:0]; n8_is_signed = sv;
            end else begin
                n16_in_valid = iv; n16_out_ready = orr; n16_a = av[15:0]; n16_b = bv[15:0]; n16_is_signed = sv;
            end
            #1;
            ov = (which == 0) ? n8_out_valid : n16_out_valid;
            ir = (which == 0) ? n8_in_ready  : n16_in_ready;
            o  = (which == 0) ? {48'b0, n8_out} : {32'b0, n16_out};
            total++;
            if (ir !== !(ov && !orr)) begin bad++; $display("FAIL rnd%0d_in_ready_c%0d: got %b want %b", w, cyc, ir, !(ov && !orr)); end
            if (prev_stall) begin
                total++;
                if (ov !== 1'b1 || o !== prev_out) begin bad++; $display("FAIL rnd%0d_hold_c%0d: got %b/%h want 1/%h", w, cyc, ov, o, prev_out); end
            end
            if (ov === 1'b1 && orr) begin
                total++;
                if (q.size() == 0 || o !== q[0]) begin
                    bad++;
                    $display("FAIL rnd%0d_data_%0d: got %h want %h", w, got, o, (q.size() > 0) ? q[0] : 64'hx);
                end
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end
            if (iv && ir === 1'b1) begin
                r = ref_mult(av, bv, sv, w);
                q.push_back(r[63:0]);
                sent++;
            end
            prev_stall = ov && !orr;
            prev_out = o;
            tick();
            cyc++;
        end
        if (which == 0) begin n8_in_valid = 1'b0; n8_out_ready = 1'b1; end
        else begin n16_in_valid = 1'b0; n16_out_ready = 1'b1; end
        total++; if (got != n || q.size() != 0) begin bad++; $display("FAIL rnd%0d_count: got %0d left %0d want %0d left 0", w, got, q.size(), n); end
    endtask

    initial begin
        m_in_valid = 1'b0;  m_a = '0;  m_b = '0;  m_is_signed = 1'b0;  m_out_ready = 1'b1;
        n8_in_valid = 1'b0; n8_a = '0; n8_b = '0; n8_is_signed = 1'b0; n8_out_ready = 1'b1;
        n16_in_valid = 1'b0; n16_a = '0; n16_b = '0; n16_is_signed = 1'b0; n16_out_ready = 1'b1;
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random(0, 150);
        test_random(1, 150);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 4..64).
REQ-002 SHALL have parameter STAGES, default 3, pipeline register stages from operand capture to result (legal 1..6).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand transfer request.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand pair this cycle.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-010 SHALL have port out_valid, output, 1, product available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-012 SHALL have port out, output, 2*WIDTH, full-width product.

Function
REQ-013 SHALL transfer an input when in_valid && in_ready at a rising edge, capturing a, b and is_signed together.
REQ-014 SHALL transfer an output when out_valid && out_ready at a rising edge.
REQ-015 SHALL produce out exactly equal to a*b, modulo 2^(2*WIDTH): unsigned for is_signed=0, signed for is_signed=1.
REQ-016 SHALL implement signed mode by Baugh-Wooley partial-product inversion plus correction constants, not by negating operands.
REQ-017 SHALL reduce partial products with a 3:2 carry-save tree, layered with the carry vector shifted left one bit per layer, until two vectors remain.
REQ-018 SHALL add the final two vectors with a log-depth parallel-prefix adder, with no ripple across the full width.
REQ-019 SHALL place the STAGES registers at evenly spaced CSA layers, with the last register after the prefix adder, so that out is registered.
REQ-020 SHALL present the result STAGES cycles after input transfer when out_ready is held 1, with one result per cycle sustained.
REQ-021 SHALL carry a valid bit per stage; bubbles propagate without affecting other transactions.
REQ-022 SHALL stall all stages when out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
REQ-023 SHALL hold out and out_valid stable while stalled, and lose or duplicate no transaction.
REQ-024 SHALL accept a new input in the same cycle the stalled output transfers (full throughput on release).
REQ-025 SHALL keep in_ready purely combinational from out_ready and out_valid, with no dependency on in_valid.
REQ-026 SHALL ignore a, b and is_signed when no input transfer occurs.

Reset
REQ-027 SHALL clear all stage valid bits and out_valid to 0, and out to 0, while rst_n=0.
REQ-028 SHALL drive in_ready=1 during and after reset.
REQ-029 SHALL discard in-flight transactions when reset asserts mid-operation; none emerge after release.
REQ-030 SHALL leave datapath registers other than out unreset.

Structure
REQ-031 SHALL place in package wallace_pkg: the max-stage constant, a function returning the CSA layer count for a given operand count, and a function returning the Baugh-Wooley correction constant for WIDTH.
REQ-032 SHALL use one sub-module, csa_row: a parametrised-width 3:2 compressor producing sum and carry vectors (carry shifted left, LSB 0).
REQ-033 SHALL stay within 120-400 lines of RTL for the top module plus csa_row.

Verification
REQ-034 Unsigned test, WIDTH=32: a=b=0xFFFFFFFF, is_signed=0 -> out=0xFFFFFFFE00000001, exactly 3 cycles after transfer.
REQ-035 Signed test, WIDTH=32: a=b=0xFFFFFFFF, is_signed=1 -> out=0x0000000000000001; a=b=0x80000000 -> out=0x4000000000000000; a=0x80000000, b=1 -> out=0xFFFFFFFF80000000.
REQ-036 Back-to-back test: 10 consecutive inputs with alternating is_signed and out_ready=1 -> 10 correct outputs on consecutive cycles, in order.
REQ-037 Backpressure test: out_ready=0 for 5 cycles with pipe full -> in_ready=0 and out stable; release -> all results delivered once, in order.
REQ-038 Reset test: assert rst_n=0 with 2 transactions in flight -> out_valid=0 immediately and no stale output after release; random signed/unsigned regression at WIDTH=8, STAGES=1 and WIDTH=16, STAGES=4 matches the model.
